// File: rtl/eth_seq_checker_if.sv
// Simulated-ethernet beat stream: 4-bit address, 256-bit payload,
// packet delimiters and a valid/ready handshake.
interface eth_seq_checker_if;
  logic [3:0]   addr;
  logic [255:0] data;
  logic         sop;
  logic         eop;
  logic         valid;
  logic         ready;

  modport master (
    output addr, data, sop, eop, valid,
    input  ready
  );

  modport slave (
    input  addr, data, sop, eop, valid,
    output ready
  );
endinterface

// File: rtl/eth_seq_checker.sv
// Receive-side checker for sequential-counter traffic: address, padding,
// per-source counter continuity and 4-beat framing, with stats.
module eth_seq_checker #(
  parameter logic [3:0]  MY_ADDR      = 4'h0,
  parameter bit          STALL_EN     = 1'b0,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1,
  parameter int unsigned STALL_THRESH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              clear_stats,
  eth_seq_checker_if.slave  rx,
  output logic              error,
  output logic [2:0]        err_code,
  output logic [63:0]       err_data,
  output logic [31:0]       beats0,
  output logic [31:0]       beats1,
  output logic [31:0]       pkts0,
  output logic [31:0]       pkts1,
  output logic [1:0]        synced
);

  typedef enum logic {
    WAIT_SOP,
    IN_PKT
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic [1:0]  idx_q;
  logic [1:0]  idx_d;
  logic        lid_q;
  logic        lid_d;
  logic        fsm_err;

  logic [15:0] lfsr;
  logic        lfsr_fb;
  logic        stall;
  logic        ready_q;

  logic [63:0] exp_q [0:1];

  logic        accept;
  logic        id;
  logic [63:0] cnt;
  logic        addr_err;
  logic        pad_err;
  logic        seq_err;
  logic        pos_err;
  logic        frm_err;
  logic [2:0]  code;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  assign rx.ready = ready_q;
  assign accept   = rx.valid & ready_q;
  assign id       = rx.data[64];
  assign cnt      = rx.data[63:0];

  assign lfsr_fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
  assign stall   = STALL_EN &
                   ({28'd0, lfsr[3:0]} < STALL_THRESH);

  assign addr_err = (rx.addr != MY_ADDR);
  assign pad_err  = |rx.data[255:65];
  assign seq_err  = synced[id] & (cnt != exp_q[id]);
  // Delimiters must agree with the counter's position in its 4-beat group.
  assign pos_err  = (rx.sop != (cnt[1:0] == 2'd0)) |
                    (rx.eop != (cnt[1:0] == 2'd3));
  assign frm_err  = fsm_err | pos_err;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    lid_d   = lid_q;
    fsm_err = 1'b0;
    if (accept) begin
      unique case (state_q)
        WAIT_SOP: begin
          if (rx.sop & ~rx.eop) begin
            lid_d   = id;
            idx_d   = 2'd1;
            state_d = IN_PKT;
          end else begin
            fsm_err = 1'b1;
          end
        end
        IN_PKT: begin
          if (rx.sop) begin
            fsm_err = 1'b1;
            if (~rx.eop) begin
              lid_d = id;
              idx_d = 2'd1;
            end else begin
              state_d = WAIT_SOP;
            end
          end else if ((id != lid_q) ||
                       (rx.eop != (idx_q == 2'd3))) begin
            fsm_err = 1'b1;
            state_d = WAIT_SOP;
          end else if (rx.eop) begin
            state_d = WAIT_SOP;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
      endcase
    end
  end

  // Lowest code wins when a beat fails several checks.
  always_comb begin
    code = 3'd0;
    if (frm_err)  code = 3'd4;
    if (seq_err)  code = 3'd3;
    if (pad_err)  code = 3'd2;
    if (addr_err) code = 3'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr     <= LFSR_SEED;
      ready_q  <= 1'b0;
      state_q  <= WAIT_SOP;
      idx_q    <= 2'd0;
      lid_q    <= 1'b0;
      synced   <= 2'b00;
      exp_q[0] <= 64'd0;
      exp_q[1] <= 64'd0;
      error    <= 1'b0;
      err_code <= 3'd0;
      err_data <= 64'd0;
      beats0   <= 32'd0;
      beats1   <= 32'd0;
      pkts0    <= 32'd0;
      pkts1    <= 32'd0;
    end else begin
      lfsr    <= {lfsr[14:0], lfsr_fb};
      ready_q <= enable & ~stall;
      state_q <= state_d;
      idx_q   <= idx_d;
      lid_q   <= lid_d;

      if (accept) begin
        if (synced[id]) begin
          exp_q[id] <= cnt + 64'd1;
        end else if (rx.sop) begin
          synced[id] <= 1'b1;
          exp_q[id]  <= cnt + 64'd1;
        end
      end

      if (clear_stats) begin
        error    <= 1'b0;
        err_code <= 3'd0;
        err_data <= 64'd0;
        beats0   <= 32'd0;
        beats1   <= 32'd0;
        pkts0    <= 32'd0;
        pkts1    <= 32'd0;
      end else if (accept) begin
        if (!error && (code != 3'd0)) begin
          error    <= 1'b1;
          err_code <= code;
          err_data <= cnt;
        end
        if (id) begin
          beats1 <= sat_inc(beats1);
          if (rx.eop) pkts1 <= sat_inc(pkts1);
        end else begin
          beats0 <= sat_inc(beats0);
          if (rx.eop) pkts0 <= sat_inc(pkts0);
        end
      end
    end
  end

endmodule

// File: tb/tb_eth_seq_checker.sv
// Directed bench for eth_seq_checker: one plain instance and one
// instance with pseudo-random backpressure.
module tb_eth_seq_checker;

  logic clk = 1'b0;
  logic reset;
  logic enable;
  logic clear_stats;

  always #5 clk = ~clk;

  eth_seq_checker_if m_if ();
  eth_seq_checker_if s_if ();

  logic        m_error, s_error;
  logic [2:0]  m_code, s_code;
  logic [63:0] m_edata, s_edata;
  logic [31:0] m_beats0, m_beats1, m_pkts0, m_pkts1;
  logic [31:0] s_beats0, s_beats1, s_pkts0, s_pkts1;
  logic [1:0]  m_synced, s_synced;

  int n_chk  = 0;
  int n_pass = 0;
  bit saw_stall;

  eth_seq_checker #(
    .MY_ADDR(4'h0), .STALL_EN(1'b0),
    .LFSR_SEED(16'hACE1), .STALL_THRESH(4)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .clear_stats(clear_stats), .rx(m_if),
    .error(m_error), .err_code(m_code), .err_data(m_edata),
    .beats0(m_beats0), .beats1(m_beats1),
    .pkts0(m_pkts0), .pkts1(m_pkts1), .synced(m_synced)
  );

  eth_seq_checker #(
    .MY_ADDR(4'h0), .STALL_EN(1'b1),
    .LFSR_SEED(16'hACE1), .STALL_THRESH(8)
  ) dut_s (
    .clk(clk), .reset(reset), .enable(enable),
    .clear_stats(clear_stats), .rx(s_if),
    .error(s_error), .err_code(s_code), .err_data(s_edata),
    .beats0(s_beats0), .beats1(s_beats1),
    .pkts0(s_pkts0), .pkts1(s_pkts1), .synced(s_synced)
  );

  task automatic send(input bit sel, input logic [3:0] a,
                      input logic id, input logic [63:0] c,
                      input logic [190:0] pad,
                      input bit sp, input bit ep);
    bit done;
    done = 1'b0;
    if (!sel) begin
      m_if.addr = a; m_if.data = {pad, id, c};
      m_if.sop = sp; m_if.eop = ep; m_if.valid = 1'b1;
    end else begin
      s_if.addr = a; s_if.data = {pad, id, c};
      s_if.sop = sp; s_if.eop = ep; s_if.valid = 1'b1;
    end
    for (int i = 0; i < 200 && !done; i++) begin
      if ((sel ? s_if.ready : m_if.ready) === 1'b1) done = 1'b1;
      else saw_stall = 1'b1;
      @(negedge clk);
    end
    if (!done) begin
      n_chk++;
      $display("FAIL accept_timeout got no ready in 200 cycles exp ready=1");
    end
  endtask

  task automatic beat(input bit sel, input logic id, input logic [63:0] c);
    send(sel, 4'h0, id, c, '0, c[1:0] == 2'd0, c[1:0] == 2'd3);
  endtask

  task automatic idle();
    m_if.valid = 1'b0;
    s_if.valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_reset();
    m_if.valid = 1'b0;
    s_if.valid = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_chk++; if (m_if.ready !== 1'b0) $display("FAIL rst_ready got %b exp 0", m_if.ready); else n_pass++;
    n_chk++; if ({m_error, m_code, m_edata} !== 68'd0) $display("FAIL rst_err got %b/%0d/%0h exp 0", m_error, m_code, m_edata); else n_pass++;
    n_chk++; if ({m_beats0, m_beats1, m_pkts0, m_pkts1} !== 128'd0) $display("FAIL rst_counters got %0d %0d %0d %0d exp 0", m_beats0, m_beats1, m_pkts0, m_pkts1); else n_pass++;
    n_chk++; if (m_synced !== 2'b00) $display("FAIL rst_synced got %b exp 00", m_synced); else n_pass++;
    reset = 1'b0;
    @(negedge clk);
    n_chk++; if (m_if.ready !== 1'b1) $display("FAIL ready_after_rst got %b exp 1", m_if.ready); else n_pass++;
    enable = 1'b0;
    @(negedge clk);
    n_chk++; if (m_if.ready !== 1'b0) $display("FAIL enable_low_ready got %b exp 0", m_if.ready); else n_pass++;
    enable = 1'b1;
    @(negedge clk);
    n_chk++; if (m_if.ready !== 1'b1) $display("FAIL enable_high_ready got %b exp 1", m_if.ready); else n_pass++;
  endtask

  task automatic test_stream();
    do_reset();
    saw_stall = 1'b0;
    for (int c = 0; c < 16; c++) beat(1'b0, 1'b0, 64'(c));
    idle();
    n_chk++; if (saw_stall !== 1'b0) $display("FAIL stream_no_stall got %b exp 0", saw_stall); else n_pass++;
    n_chk++; if (m_beats0 !== 32'd16) $display("FAIL stream_beats0 got %0d exp 16", m_beats0); else n_pass++;
    n_chk++; if (m_pkts0 !== 32'd4) $display("FAIL stream_pkts0 got %0d exp 4", m_pkts0); else n_pass++;
    n_chk++; if (m_synced !== 2'b01) $display("FAIL stream_synced got %b exp 01", m_synced); else n_pass++;
    n_chk++; if ({m_error, m_code} !== 4'd0) $display("FAIL stream_error got %b/%0d exp 0/0", m_error, m_code); else n_pass++;
  endtask

  task automatic test_mid_packet();
    do_reset();
    for (int c = 6; c < 16; c++) beat(1'b0, 1'b0, 64'(c));
    idle();
    n_chk++; if ({m_error, m_code} !== {1'b1, 3'd4}) $display("FAIL mid_code got %b/%0d exp 1/4", m_error, m_code); else n_pass++;
    n_chk++; if (m_edata !== 64'd6) $display("FAIL mid_edata got %0d exp 6", m_edata); else n_pass++;
    n_chk++; if (m_synced !== 2'b01) $display("FAIL mid_synced got %b exp 01", m_synced); else n_pass++;
    n_chk++; if ({m_beats0, m_pkts0} !== {32'd10, 32'd3}) $display("FAIL mid_counts got %0d/%0d exp 10/3", m_beats0, m_pkts0); else n_pass++;
  endtask

  task automatic test_seq_gap();
    do_reset();
    for (int c = 0; c < 4; c++) beat(1'b0, 1'b1, 64'(c));
    for (int c = 8; c < 12; c++) beat(1'b0, 1'b1, 64'(c));
    idle();
    n_chk++; if ({m_error, m_code} !== {1'b1, 3'd3}) $display("FAIL gap_code got %b/%0d exp 1/3", m_error, m_code); else n_pass++;
    n_chk++; if (m_edata !== 64'd8) $display("FAIL gap_edata got %0d exp 8", m_edata); else n_pass++;
    n_chk++; if (m_pkts1 !== 32'd2) $display("FAIL gap_pkts1 got %0d exp 2", m_pkts1); else n_pass++;
    for (int c = 12; c < 16; c++) beat(1'b0, 1'b1, 64'(c));
    idle();
    n_chk++; if ({m_code, m_edata} !== {3'd3, 64'd8}) $display("FAIL gap_hold got %0d/%0d exp 3/8", m_code, m_edata); else n_pass++;
    n_chk++; if ({m_beats1, m_pkts1, m_beats0} !== {32'd12, 32'd3, 32'd0}) $display("FAIL gap_counts got %0d/%0d/%0d exp 12/3/0", m_beats1, m_pkts1, m_beats0); else n_pass++;
    n_chk++; if (m_synced !== 2'b10) $display("FAIL gap_synced got %b exp 10", m_synced); else n_pass++;
  endtask

  task automatic test_wrap();
    logic [63:0] c;
    do_reset();
    c = 64'hFFFF_FFFF_FFFF_FFFC;
    for (int i = 0; i < 8; i++) begin
      beat(1'b0, 1'b0, c);
      c = c + 64'd1;
    end
    idle();
    n_chk++; if ({m_error, m_code} !== 4'd0) $display("FAIL wrap_error got %b/%0d exp 0/0", m_error, m_code); else n_pass++;
    n_chk++; if ({m_beats0, m_pkts0} !== {32'd8, 32'd2}) $display("FAIL wrap_counts got %0d/%0d exp 8/2", m_beats0, m_pkts0); else n_pass++;
  endtask

  task automatic test_back_to_back_stall();
    do_reset();
    saw_stall = 1'b0;
    for (int k = 0; k < 4; k++)
      for (int id = 0; id < 2; id++)
        for (int b = 0; b < 4; b++)
          beat(1'b1, id[0], 64'(k * 4 + b));
    idle();
    n_chk++; if (saw_stall !== 1'b1) $display("FAIL stall_seen got %b exp 1", saw_stall); else n_pass++;
    n_chk++; if ({s_beats0, s_beats1} !== {32'd16, 32'd16}) $display("FAIL stall_beats got %0d/%0d exp 16/16", s_beats0, s_beats1); else n_pass++;
    n_chk++; if ({s_pkts0, s_pkts1} !== {32'd4, 32'd4}) $display("FAIL stall_pkts got %0d/%0d exp 4/4", s_pkts0, s_pkts1); else n_pass++;
    n_chk++; if ({s_error, s_code} !== 4'd0) $display("FAIL stall_error got %b/%0d exp 0/0", s_error, s_code); else n_pass++;
    n_chk++; if (s_synced !== 2'b11) $display("FAIL stall_synced got %b exp 11", s_synced); else n_pass++;
  endtask

  task automatic test_priority_clear_reset();
    logic [190:0] pad;
    do_reset();
    pad = '0;
    pad[35] = 1'b1;
    send(1'b0, 4'h1, 1'b0, 64'd4, pad, 1'b1, 1'b0);
    idle();
    n_chk++; if ({m_error, m_code} !== {1'b1, 3'd1}) $display("FAIL prio_code got %b/%0d exp 1/1", m_error, m_code); else n_pass++;
    n_chk++; if (m_edata !== 64'd4) $display("FAIL prio_edata got %0d exp 4", m_edata); else n_pass++;
    clear_stats = 1'b1;
    @(negedge clk);
    clear_stats = 1'b0;
    @(negedge clk);
    n_chk++; if ({m_error, m_code, m_edata} !== 68'd0) $display("FAIL clr_err got %b/%0d/%0d exp 0", m_error, m_code, m_edata); else n_pass++;
    n_chk++; if ({m_beats0, m_pkts0} !== 64'd0) $display("FAIL clr_counts got %0d/%0d exp 0/0", m_beats0, m_pkts0); else n_pass++;
    n_chk++; if (m_synced !== 2'b01) $display("FAIL clr_synced got %b exp 01", m_synced); else n_pass++;
    beat(1'b0, 1'b0, 64'd5);
    beat(1'b0, 1'b0, 64'd6);
    idle();
    n_chk++; if ({m_error, m_beats0} !== {1'b0, 32'd2}) $display("FAIL resume got %b/%0d exp 0/2", m_error, m_beats0); else n_pass++;
    reset = 1'b1;
    @(negedge clk);
    n_chk++; if ({m_if.ready, m_synced, m_error, m_beats0} !== 36'd0) $display("FAIL midrst got %b/%b/%b/%0d exp 0", m_if.ready, m_synced, m_error, m_beats0); else n_pass++;
    reset = 1'b0;
    @(negedge clk);
    beat(1'b0, 1'b0, 64'd7);
    idle();
    n_chk++; if ({m_error, m_code, m_edata} !== {1'b1, 3'd4, 64'd7}) $display("FAIL midrst_fsm got %b/%0d/%0d exp 1/4/7", m_error, m_code, m_edata); else n_pass++;
  endtask

  initial begin
    reset = 1'b1;
    enable = 1'b1;
    clear_stats = 1'b0;
    saw_stall = 1'b0;
    m_if.valid = 1'b0; m_if.addr = '0; m_if.data = '0;
    m_if.sop = 1'b0; m_if.eop = 1'b0;
    s_if.valid = 1'b0; s_if.addr = '0; s_if.data = '0;
    s_if.sop = 1'b0; s_if.eop = 1'b0;
    test_reset();
    test_stream();
    test_mid_packet();
    test_seq_gap();
    test_wrap();
    test_back_to_back_stall();
    test_priority_clear_reset();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/eth_seq_checker.md
Name: eth_seq_checker

Overview:
- Downstream consumer of the sequential-counter traffic generator, attached to the receive side of the simulated-ethernet stream.
- Accepts beats, applies optional pseudo-random backpressure, and checks each beat: destination address, zero padding, per-source counter continuity, and 4-beat packet framing.
- Exposes sticky error status, first-error capture and per-source statistics for the testbench and monitors.

Parameters:
- MY_ADDR, 4'h0, station address every received beat must carry in rx.addr.
- STALL_EN, 0, 1 = deassert ready pseudo-randomly from an LFSR; 0 = ready held high.
- LFSR_SEED, 16'hACE1, reset value of the 16-bit Fibonacci LFSR (taps 16,14,13,11). Must be nonzero.
- STALL_THRESH, 4, ready is low in a cycle when lfsr[3:0] < STALL_THRESH. Range 0..15.

Ports:
- clk  input  1  sole clock.
- reset  input  1  synchronous, active-high.
- enable  input  1  when low, ready is forced low; no beats are accepted.
- clear_stats  input  1  single-cycle pulse: zeroes counters and error state; sync state is kept.
- rx  t_ETH_STREAM.rx  -  stream input: addr[3:0], data[255:0], sop, eop, valid in; ready out.
- error  output  1  sticky; set on the first check failure.
- err_code  output  3  code of the first failure: 1 addr, 2 pad, 3 sequence, 4 framing; 0 = none.
- err_data  output  64  data[63:0] of the first failing beat.
- beats0, beats1  output  32 each  accepted beats per source id (data[64]).
- pkts0, pkts1  output  32 each  completed packets (eop accepted) per source id.
- synced  output  2  bit n set once source n has delivered its first sop.

Behaviour:
- Acceptance: a beat is accepted when valid & ready at the rising edge of clk. All state updates occur only on accept.
- ready:
  - Registered.
  - Equals enable & ~stall, where stall = STALL_EN & (lfsr[3:0] < STALL_THRESH).
  - The LFSR advances every cycle, regardless of valid.
- Reset: ready=0, lfsr=LFSR_SEED, error=0, err_code=0, err_data=0, all counters=0, synced=0, FSM=WAIT_SOP. ready may first rise on the cycle after reset deasserts.
- Source state: per id, hold a 64-bit expected value and a synced bit.
- Framing FSM: states WAIT_SOP and IN_PKT, plus a 2-bit beat index and a latched id.
  - WAIT_SOP, beat with sop=1 and eop=0: latch id, set index=1, go to IN_PKT.
  - WAIT_SOP, beat with sop=0, or sop=1 with eop=1: framing error; stay in WAIT_SOP.
  - IN_PKT: the beat must have sop=0 and id equal to the latched id.
    - eop must be 1 exactly when index==3.
    - On eop go to WAIT_SOP; otherwise increment index.
  - IN_PKT, sop=1 arrives: framing error; treat the beat as a new packet start (relatch id, index=1).
  - IN_PKT, wrong eop or wrong id: framing error; return to WAIT_SOP.
- Sequence check, evaluated on every accepted beat:
  - Unsynced source, beat with sop=1: take the beat's counter as the start value, set synced, set expected=counter+1. No error.
  - Unsynced source, non-sop beat: ignored for sequence purposes only; framing and address checks still apply.
  - Synced source: counter must equal expected, else sequence error. Then expected = counter+1, so the checker resynchronises after a mismatch.
  - Arithmetic is 64-bit modulo; FFFF_FFFF_FFFF_FFFF → 0 is legal.
  - Framing also requires sop == (counter[1:0]==0) and eop == (counter[1:0]==3).
- Address check: rx.addr != MY_ADDR is an addr error.
- Pad check: data[255:65] != 0 is a pad error.
- Multiple failures on one beat: report the lowest code.
- Error capture:
  - error, err_code and err_data are captured only when error==0 (first-error capture).
  - Later errors do not overwrite them; checking continues.
- Counters:
  - beats/pkts saturate at FFFF_FFFF.
  - They count beats from the decoded data[64] even when the beat has errors.
- clear_stats:
  - Takes priority over a same-cycle accept for counters and error state.
  - The FSM and sync state still update from that beat.
- Timing: outputs are registered and update one cycle after the accepting edge.

Test Plan:
- Reset, STALL_EN=0, one source id=0, addr=MY_ADDR, counter 0..15 → ready=1 from the cycle after reset; beats0=16, pkts0=4, synced=01, error=0.
- Same stream starting at counter 8, sent mid-packet as 6,7,8… → beats 6 and 7 are framing errors (no sop); synced at 8; error=1, err_code=4, err_data=6.
- Source 1 sends 0..3, skips 4..7, sends 8..11 → err_code=3, err_data=8; pkts1=2; a further 12..15 causes no new capture.
- Counter near wrap, FFFF_FFFF_FFFF_FFFC..+7 → wraps to 0..3 cleanly; error=0, pkts=2.
- STALL_EN=1, THRESH=8, with id 0 and id 1 packets alternating → no beat is lost or duplicated while ready toggles; beats0=beats1=total sent; no error.
- Beat with addr=MY_ADDR+1 and data[100]=1 → err_code=1 (lowest code wins). clear_stats pulse → error=0 and counters=0 while synced is retained. Assert reset mid-packet → all outputs return to reset values and the FSM returns to WAIT_SOP.
